// File: rtl/beat_fifo_pkg.sv
// Shared handshake definitions for the beat FIFO: default beat width,
// the beat data type and the wrapping pointer increment.
package beat_fifo_pkg;

   localparam int DATA_W_DEF = 3;

   typedef logic [DATA_W_DEF-1:0] beat_t;

   // Advance a circular-buffer pointer, rolling from depth-1 back to 0.
   function automatic int unsigned ptr_wrap_inc(input int unsigned ptr,
                                                input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage : beat_fifo_pkg

// File: rtl/beat_fifo.sv
// Valid/ready FIFO stage placed between the pipe stage and the slave stage.
// Buffers up to DEPTH beats so slave back-pressure does not stall the pipe.
// Outputs depend only on registered state: no path from ready_down to
// ready_up, nor from valid_up/data_up to valid_down/data_down.
module beat_fifo
   import beat_fifo_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = 4,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              valid_up,
   input  logic [DATA_W-1:0] data_up,
   output logic              ready_up,
   output logic              valid_down,
   output logic [DATA_W-1:0] data_down,
   input  logic              ready_down,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   // Storage is deliberately left unreset; only pointers, count and the
   // upstream-enable flag are cleared.
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              up_en_q;

   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   // Handshake decode: a beat moves only when both sides agree.
   always_comb begin
      full  = (cnt_q == CNT_W'(DEPTH));
      empty = (cnt_q == '0);
      push  = valid_up & ready_up;
      pop   = valid_down & ready_down;
   end

   // Next pointers and occupancy; simultaneous push and pop leaves count as is.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = PTR_W'(ptr_wrap_inc(32'(wr_ptr_q), DEPTH));
      end
      if (pop) begin
         rd_ptr_d = PTR_W'(ptr_wrap_inc(32'(rd_ptr_q), DEPTH));
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Storage write, pointers, counter and upstream enable; async clear.
   // up_en is raised on the first edge after reset release, holding
   // ready_up low through that edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         up_en_q  <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= data_up;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         up_en_q  <= 1'b1;
      end
   end

   // Outputs from registered state only; data is forced to zero when empty.
   always_comb begin
      ready_up   = up_en_q & ~full;
      valid_down = ~empty;
      data_down  = empty ? '0 : mem_q[rd_ptr_q];
      count      = cnt_q;
   end

endmodule : beat_fifo

// File: tb/tb_beat_fifo.sv
// Self-checking bench for beat_fifo: a queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_beat_fifo;

   localparam int DATA_W = 3;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              sys_clk;
   logic              rst_n;
   logic              valid_up;
   logic [DATA_W-1:0] data_up;
   logic              ready_up;
   logic              valid_down;
   logic [DATA_W-1:0] data_down;
   logic              ready_down;
   logic [CNT_W-1:0]  count;

   int n_cmp  = 0;
   int n_fail = 0;

   beat_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .valid_up   (valid_up),
      .data_up    (data_up),
      .ready_up   (ready_up),
      .valid_down (valid_down),
      .data_down  (data_down),
      .ready_down (ready_down),
      .count      (count)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Reference model: queue of stored beats plus the upstream enable flag.
   logic [DATA_W-1:0] mq[$];
   bit                m_up_en = 1'b0;

   always @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_up_en = 1'b0;
      end else begin
         bit do_push;
         bit do_pop;
         do_push = valid_up && m_up_en && (mq.size() < DEPTH);
         do_pop  = ready_down && (mq.size() != 0);
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(data_up);
         m_up_en = 1'b1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   bit cmp_en = 1'b0;
   always @(negedge sys_clk) begin
      if (cmp_en) begin
         int exp_cnt;
         exp_cnt = mq.size();
         check("model_count", int'(count), exp_cnt);
         check("model_valid_down", int'(valid_down), int'(exp_cnt != 0));
         check("model_ready_up", int'(ready_up), int'(m_up_en && exp_cnt < DEPTH));
         check("model_data_down", int'(data_down), (exp_cnt != 0) ? int'(mq[0]) : 0);
         check("count_le_depth", int'(count <= CNT_W'(DEPTH)), 1);
      end
   end

   // Advance one clock; returns just after the falling edge.
   task automatic cyc();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   initial begin
      int p_v;
      int p_r;
      rst_n      = 1'b0;
      valid_up   = 1'b0;
      data_up    = '0;
      ready_down = 1'b0;
      @(negedge sys_clk);
      cmp_en = 1'b1;

      // Reset held for 3 cycles.
      repeat (3) cyc();
      check("rst_valid_down", int'(valid_down), 0);
      check("rst_ready_up", int'(ready_up), 0);
      check("rst_count", int'(count), 0);
      check("rst_data_down", int'(data_down), 0);
      rst_n = 1'b1;
      check("rel_ready_up_before_edge", int'(ready_up), 0);
      cyc();
      check("rel_ready_up", int'(ready_up), 1);
      $display("reset: released, ready_up=%0d", ready_up);

      // Fill with 1..4, downstream stalled.
      for (int i = 0; i < DEPTH; i++) begin
         valid_up = 1'b1;
         data_up  = DATA_W'(i + 1);
         cyc();
         check("fill_count", int'(count), i + 1);
         $display("fill: push %0d count=%0d", i + 1, count);
      end
      check("full_ready_up", int'(ready_up), 0);
      data_up = 3'd5;
      cyc();
      check("full_hold_count", int'(count), DEPTH);
      check("full_head", int'(data_down), 1);

      // Drain in order.
      valid_up   = 1'b0;
      ready_down = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_data", int'(data_down), i + 1);
         cyc();
         check("drain_count", int'(count), DEPTH - 1 - i);
         $display("drain: pop %0d count=%0d", i + 1, count);
      end
      check("drain_empty", int'(valid_down), 0);

      // Streaming through the pointer wrap, one beat per cycle.
      for (int i = 0; i < 8; i++) begin
         valid_up = 1'b1;
         data_up  = DATA_W'(i);
         cyc();
         check("stream_data", int'(data_down), i);
         check("stream_count", int'(count), 1);
         $display("stream: in %0d out %0d count=%0d", i, data_down, count);
      end
      valid_up = 1'b0;
      cyc();
      check("stream_end_count", int'(count), 0);

      // Full with simultaneous pop request: only the pop happens.
      ready_down = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_up = 1'b1;
         data_up  = DATA_W'(i + 1);
         cyc();
      end
      check("fp_full", int'(count), DEPTH);
      data_up    = 3'd6;
      ready_down = 1'b1;
      cyc();
      check("fp_pop_only_count", int'(count), 3);
      check("fp_pop_only_data", int'(data_down), 2);
      check("fp_ready_up", int'(ready_up), 1);
      cyc();
      check("fp_push_pop_count", int'(count), 3);
      check("fp_push_pop_data", int'(data_down), 3);
      $display("fullpop: count=%0d head=%0d", count, data_down);
      valid_up   = 1'b0;
      ready_down = 1'b0;

      // Asynchronous reset between edges with 3 beats held.
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid_down", int'(valid_down), 0);
      check("arst_count", int'(count), 0);
      check("arst_data_down", int'(data_down), 0);
      check("arst_ready_up", int'(ready_up), 0);
      $display("async reset: count=%0d valid_down=%0d", count, valid_down);
      @(negedge sys_clk);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Random traffic in phases of differing push/pop bias.
      for (int ph = 0; ph < 6; ph++) begin
         p_v = (ph % 3 == 0) ? 90 : ((ph % 3 == 1) ? 30 : 60);
         p_r = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 90 : 60);
         for (int i = 0; i < 80; i++) begin
            valid_up   = ($urandom_range(0, 99) < p_v);
            ready_down = ($urandom_range(0, 99) < p_r);
            data_up    = DATA_W'($urandom);
            cyc();
            $display("rand: v=%0d d=%0d r=%0d -> vd=%0d dd=%0d cnt=%0d",
                     valid_up, data_up, ready_down, valid_down, data_down, count);
         end
      end

      // Mid-random async reset then brief resumption.
      #2 rst_n = 1'b0;
      #1;
      check("arst2_count", int'(count), 0);
      @(negedge sys_clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         valid_up   = $urandom_range(0, 1);
         ready_down = $urandom_range(0, 1);
         data_up    = DATA_W'($urandom);
         cyc();
      end

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_beat_fifo
